fifo_ctrl: RTL

- Sequencing controller for the FIFO RAM. Accepts push/pop requests and decides which ones are legal.
- Owns the write and read pointers and drives RAM address and enable strobes.
- Tracks occupancy and publishes full/empty, almost-full/almost-empty and error pulses to producer and consumer.
- Sits between the producer/consumer handshake logic and the dual-port FIFO RAM; replaces free-running pointer counters with a single coordinated controller.

---
 rtl/fifo_ctrl_pkg.sv | 28 ++
 rtl/fifo_ctrl_ptr.sv | 37 +++
 rtl/fifo_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared types, sizes and helpers for the FIFO sequencing controller.
//   maxramsize : number of RAM entries the controller is built for
//   RAM_size   : RAM address width
//   ptr_t      : RAM address / pointer type
//   count_t    : occupancy type, holds 0..maxramsize
//   next_ptr() : pointer increment with explicit wrap (no reliance on binary overflow)
package fifo_ctrl_pkg;

    typedef logic bit_t;

    localparam int unsigned maxramsize = 16;
    localparam int unsigned RAM_size   = (maxramsize > 1) ? $clog2(maxramsize) : 1;
    localparam int unsigned CountW     = $clog2(maxramsize + 1);

    typedef logic [RAM_size-1:0] ptr_t;
    typedef logic [CountW-1:0]   count_t;

    // Wrap is an explicit compare so non-power-of-two depths work.
    function automatic ptr_t next_ptr(input ptr_t ptr, input int unsigned depth = maxramsize);
        ptr_t w_last;
        w_last = ptr_t'(depth - 1);
        if (ptr == w_last) begin
            return '0;
        end
        return ptr + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// fifo_ptr: wrapping pointer register, resets to 0, advances by one when i_adv is high.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low reset
//   i_adv  : advance pointer at the next edge
//   o_ptr  : current pointer value
module fifo_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = maxramsize
) (
    input  logic clk,
    input  logic reset,
    input  logic i_adv,
    output ptr_t o_ptr
);

    ptr_t r_ptr;
    ptr_t w_ptr_next;

    always_comb begin
        w_ptr_next = r_ptr;
        if (i_adv) begin
            w_ptr_next = next_ptr(r_ptr, DEPTH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sequencing controller for a dual-port FIFO RAM. Decides which push/pop
// requests are legal, owns write/read pointers, tracks occupancy and publishes flags.
//   clk, reset       : clock (rising edge), asynchronous active-low reset
//   i_push, i_pop    : producer write request, consumer read request
//   o_w_add, o_w_en  : RAM write address (current write pointer) and strobe
//   o_r_add, o_r_en  : RAM read address (current read pointer) and strobe
//   o_count          : occupancy 0..DEPTH
//   o_full, o_empty, o_almost_full, o_almost_empty : decoded from registered count
//   o_overflow, o_underflow : one-cycle pulses after a rejected push / pop
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = maxramsize,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_push,
    input  logic   i_pop,
    output ptr_t   o_w_add,
    output logic   o_w_en,
    output ptr_t   o_r_add,
    output logic   o_r_en,
    output count_t o_count,
    output logic   o_full,
    output logic   o_empty,
    output logic   o_almost_full,
    output logic   o_almost_empty,
    output logic   o_overflow,
    output logic   o_underflow
);

    count_t r_count;
    count_t w_count_next;
    logic   r_overflow;
    logic   r_underflow;
    logic   w_full;
    logic   w_empty;
    logic   w_push_ok;
    logic   w_pop_ok;

    assign w_full  = (r_count == count_t'(DEPTH));
    assign w_empty = (r_count == '0);

    // Strobes are gated by reset so nothing reaches the RAM while reset is held.
    // Push on full is legal only with a simultaneous pop (RAM is read-before-write).
    // Pop on empty is never legal: there is no bypass from push to pop.
    always_comb begin
        w_pop_ok  = reset && i_pop && !w_empty;
        w_push_ok = reset && i_push && (!w_full || i_pop);
    end

    always_comb begin
        w_count_next = r_count;
        unique case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + count_t'(1);
            2'b01:   w_count_next = r_count - count_t'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_overflow  <= i_push && !w_push_ok;
            r_underflow <= i_pop && !w_pop_ok;
        end
    end

    fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_wptr (
        .clk   (clk),
        .reset (reset),
        .i_adv (w_push_ok),
        .o_ptr (o_w_add)
    );

    fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_rptr (
        .clk   (clk),
        .reset (reset),
        .i_adv (w_pop_ok),
        .o_ptr (o_r_add)
    );

    always_comb begin
        o_w_en         = w_push_ok;
        o_r_en         = w_pop_ok;
        o_count        = r_count;
        o_full         = w_full;
        o_empty        = w_empty;
        o_almost_full  = (r_count >= count_t'(AF_LEVEL));
        o_almost_empty = (r_count <= count_t'(AE_LEVEL));
        o_overflow     = r_overflow;
        o_underflow    = r_underflow;
    end

endmodule
